// File: rtl/uart_rx_ctrl_if.sv
// Checker-side bundle of the UART receive controller: strobes out, checker results in.
// Optional err_cnt member is present only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  par_err_flag;
  logic                  stp_err_flag;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  modport master (
    input  strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, par_err_flag, stp_err_flag
`ifdef UART_RX_ERR_CNT_EN
    , output err_cnt
`endif
  );

  modport slave (
    output strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, par_err_flag, stp_err_flag
`ifdef UART_RX_ERR_CNT_EN
    , input err_cnt
`endif
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame sequencer: start detection, edge/bit counting, checker strobes.
// Define UART_RX_ERR_CNT_EN to add the saturating errored-frame counter (chk.err_cnt).
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  uart_rx_ctrl_if.master        chk
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [PRESCALE_W-1:0] p_reg, edge_q, presc_legal;
  logic                  pe_reg;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic                  last_edge, data_done;
  logic                  strt_s, deser_s, par_s, stp_s;
  logic                  par_flag_q, stp_flag_q, dv_q;

  always_comb begin
    presc_legal = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32))
      presc_legal = Prescale;
  end

  assign last_edge = (edge_q == p_reg - PRESCALE_W'(1));
  assign data_done = (bit_q == BIT_CNT_W'(DATA_WIDTH));

  always_comb begin
    state_nxt = state;
    strt_s    = 1'b0;
    deser_s   = 1'b0;
    par_s     = 1'b0;
    stp_s     = 1'b0;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START:  if (last_edge) begin
                strt_s    = 1'b1;
                state_nxt = chk.strt_glitch ? IDLE : DATA;
              end
      DATA:   if (last_edge) begin
                deser_s = 1'b1;
                if (data_done) state_nxt = pe_reg ? PARITY : STOP;
              end
      PARITY: if (last_edge) begin
                par_s     = 1'b1;
                state_nxt = STOP;
              end
      STOP:   if (last_edge) begin
                stp_s     = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      p_reg      <= PRESCALE_W'(8);
      pe_reg     <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      dv_q  <= 1'b0;
      if (state == IDLE) begin
        bit_q <= '0;
        // The detection cycle itself counts as edge 0 of the start bit.
        if (!RX_IN) begin
          edge_q     <= PRESCALE_W'(1);
          p_reg      <= presc_legal;
          pe_reg     <= PAR_EN;
          par_flag_q <= 1'b0;
          stp_flag_q <= 1'b0;
        end else begin
          edge_q <= '0;
        end
      end else if (last_edge) begin
        edge_q <= '0;
        bit_q  <= (state_nxt == IDLE) ? '0 : bit_q + BIT_CNT_W'(1);
      end else begin
        edge_q <= edge_q + PRESCALE_W'(1);
      end
      if (par_s) par_flag_q <= chk.par_err;
      if (stp_s) begin
        stp_flag_q <= chk.stp_err;
        dv_q       <= ~chk.stp_err & ~par_flag_q;
      end
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)
      err_cnt_q <= '0;
    else if (stp_s && (chk.stp_err || par_flag_q) && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign chk.err_cnt = err_cnt_q;
`endif

  // Strobes are suppressed while RST is sampled so a frame aborted by reset emits nothing.
  assign chk.strt_chk_en  = strt_s  & ~RST;
  assign chk.deser_en     = deser_s & ~RST;
  assign chk.par_chk_en   = par_s   & ~RST;
  assign chk.stp_chk_en   = stp_s   & ~RST;
  assign chk.dat_samp_en  = (state != IDLE);
  assign chk.edge_cnt     = edge_q;
  assign chk.bit_cnt      = bit_q;
  assign chk.data_valid   = dv_q;
  assign chk.par_err_flag = par_flag_q;
  assign chk.stp_err_flag = stp_flag_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames expand into timed expected events, a monitor matches DUT strobes.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int PW = 6;
  localparam int BW = 4;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);

  uart_rx_ctrl_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) chk_if ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
    .Prescale(Prescale), .chk(chk_if)
  );

  always #5 CLK = ~CLK;

  // kind: 0 start check, 1 deser, 2 parity check, 3 stop check, 4 data_valid
  typedef struct {
    int cyc;
    int kind;
    int edg;
    int bitn;
    bit pf;
    bit sf;
    int ec;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  fails = 0;
  int  m_ec = 0;
  ev_t pend;
  bit  flag_pend = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_cnt"}, chk_if.edge_cnt, 0);
    check({tag, "_bit_cnt"}, chk_if.bit_cnt, 0);
    check({tag, "_strobes"}, {chk_if.dat_samp_en, chk_if.deser_en, chk_if.strt_chk_en,
                              chk_if.par_chk_en, chk_if.stp_chk_en}, 0);
    check({tag, "_data_valid"}, chk_if.data_valid, 0);
    check({tag, "_flags"}, {chk_if.par_err_flag, chk_if.stp_err_flag}, 0);
`ifdef UART_RX_ERR_CNT_EN
    check({tag, "_err_cnt"}, chk_if.err_cnt, 0);
`endif
  endtask

  // Monitor: every strobe / data_valid pops the next expected event.
  always @(negedge CLK) begin
    logic [4:0] s;
    ev_t e;
    if (flag_pend) begin
      flag_pend = 1'b0;
      check("par_err_flag", chk_if.par_err_flag, pend.pf);
      check("stp_err_flag", chk_if.stp_err_flag, pend.sf);
`ifdef UART_RX_ERR_CNT_EN
      check("err_cnt", chk_if.err_cnt, pend.ec);
`endif
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL missed_event kind %0d: seen nothing, required at cycle %0d", e.kind, e.cyc);
    end
    s = {chk_if.data_valid, chk_if.stp_chk_en, chk_if.par_chk_en,
         chk_if.deser_en, chk_if.strt_chk_en};
    for (int k = 0; k < 5; k++) begin
      if (s[k] === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event kind %0d at cycle %0d: required none", k, cyc);
        end else begin
          e = q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (k < 4) begin
            check("edge_cnt_at_strobe", chk_if.edge_cnt, e.edg);
            check("bit_cnt_at_strobe", chk_if.bit_cnt, e.bitn);
          end
          if (k == 3) begin
            pend      = e;
            flag_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic push(input int c, input int kind, input int edg, input int bitn,
                      input bit pf, input bit sf, input int ec, input int lim);
    ev_t e;
    if (c >= lim) return;
    e.cyc = c; e.kind = kind; e.edg = edg; e.bitn = bitn; e.pf = pf; e.sf = sf; e.ec = ec;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      RX_IN = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic send_frame(input int presc, input bit pe, input logic [7:0] data,
                            input bit glitch, input bit perr, input bit serr,
                            input int mid_at, input int mid_presc, input int abort_at);
    int P, nb, len, D, lim, b;
    bit clean;
    P     = (presc == 16 || presc == 32) ? presc : 8;
    nb    = glitch ? 1 : 10 + int'(pe);
    len   = P * nb;
    D     = cyc;
    lim   = (abort_at != 0) ? D + abort_at : D + len + 1;
    clean = !serr && !(pe && perr);

    push(D + P - 1, 0, P - 1, 0, 0, 0, 0, lim);
    if (!glitch) begin
      for (int i = 1; i <= DW; i++) push(D + P * (i + 1) - 1, 1, P - 1, i, 0, 0, 0, lim);
      if (pe) push(D + P * (DW + 2) - 1, 2, P - 1, DW + 1, 0, 0, 0, lim);
      if (D + len - 1 < lim) begin
        if (!clean && m_ec < 255) m_ec++;
        push(D + len - 1, 3, P - 1, nb - 1, pe && perr, serr, m_ec, lim);
        if (clean) push(D + len, 4, 0, 0, 0, 0, 0, lim);
      end
    end

    Prescale           = PW'(presc);
    PAR_EN             = pe;
    chk_if.strt_glitch = glitch;
    chk_if.par_err     = perr;
    chk_if.stp_err     = serr;
    for (int c = 0; c < len; c++) begin
      b = c / P;
      if (glitch)                RX_IN = (c < 2) ? 1'b0 : 1'b1;
      else if (b == 0)           RX_IN = 1'b0;
      else if (b <= DW)          RX_IN = data[b-1];
      else if (pe && b == DW + 1) RX_IN = ^data;
      else                       RX_IN = 1'b1;
      if (mid_at != 0 && c == mid_at) Prescale = PW'(mid_presc);
      if (abort_at != 0 && c == abort_at) RST = 1'b1;
      @(posedge CLK); #1;
      if (c == 0) begin
        check("start_dat_samp_en", chk_if.dat_samp_en, 1);
        check("start_edge_cnt", chk_if.edge_cnt, 1);
      end
      if (abort_at != 0 && c == abort_at) begin
        RST   = 1'b0;
        RX_IN = 1'b1;
        m_ec  = 0;
        check_all_zero("after_abort");
        break;
      end
    end
    RX_IN = 1'b1;
    if (glitch && abort_at == 0) begin
      check("glitch_edge_cnt", chk_if.edge_cnt, 0);
      check("glitch_dat_samp_en", chk_if.dat_samp_en, 0);
      check("glitch_flags", {chk_if.par_err_flag, chk_if.stp_err_flag}, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int presc, sel;
    chk_if.strt_glitch = 1'b0;
    chk_if.par_err     = 1'b0;
    chk_if.stp_err     = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    send_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
    idle(3);
    send_frame(8, 1, 8'hA5, 0, 1, 0, 0, 0, 0);
    idle(2);
    send_frame(16, 0, 8'h3C, 0, 0, 1, 0, 0, 0);
    idle(2);
    send_frame(8, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    idle(1);
    send_frame(8, 1, 8'h5A, 0, 0, 0, 20, 32, 0);
    send_frame(32, 0, 8'hC3, 0, 0, 0, 0, 0, 0);
    idle(2);
    send_frame(8, 1, 8'hFF, 0, 0, 0, 0, 0, 30);
    send_frame(8, 1, 8'h81, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: presc = 8;
        1: presc = 16;
        2: presc = 32;
        default: presc = int'($urandom_range(0, 63));
      endcase
      send_frame(presc, 1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0,
                 int'($urandom_range(0, 63)), 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
